// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU requesters, the memory port arbiter and the memory wrapper.
// The master modport is the arbiter's view, and the slave modport is the environment's view.
interface mem_port_arbiter_if;
    // Handshake: a requester raises x_req with its address/data and holds it until x_done
    // pulses for one cycle. The arbiter raises mem_req and holds it until mem_ack is seen,
    // or until the timeout aborts the access. mem_rdata is valid in the mem_ack cycle.
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mask;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mask, mem_ack, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done, err, stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask, dbg_state
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mask, mem_ack, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done, err, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask, dbg_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-ported memory. It includes
// a data-streak limit that prevents fetch starvation and a timeout that prevents a hung memory.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_mask_q, mem_mask_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;
    logic        err_q, err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        turnaround;
    logic        d_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            tmo_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_mask_q  <= 4'd0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mask_q  <= mem_mask_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_mask_d  = mem_mask_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        // The done cycle is a bus turnaround, so no grant is made while either done pulse is high.
        turnaround  = if_done_q | d_done_q;
        d_win       = bus.d_req & (~bus.if_req | (streak_q < STREAK_MAX));

        case (state_q)
            IDLE: begin
                if (!turnaround) begin
                    if (d_win) begin
                        state_d     = BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_mask_d  = bus.d_mask;
                        tmo_d       = 8'd0;
                        if (bus.if_req) begin
                            streak_d = (streak_q < STREAK_MAX) ? streak_q + 4'd1 : STREAK_MAX;
                        end else begin
                            streak_d = 4'd0;
                        end
                    end else if (bus.if_req) begin
                        state_d     = BUSY_I;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = 32'd0;
                        mem_mask_d  = 4'b0000;
                        tmo_d       = 8'd0;
                        streak_d    = 4'd0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    // Abort on the TIMEOUT-th busy cycle without an acknowledge.
                    if (tmo_q == TMO_LAST) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                        err_d     = 1'b1;
                        if (state_q == BUSY_I) begin
                            if_done_d  = 1'b1;
                            if_rdata_d = 32'd0;
                        end else begin
                            d_done_d  = 1'b1;
                            d_rdata_d = 32'd0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.stall     = (bus.if_req & ~if_done_q) | (bus.d_req & ~d_done_q);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_mask  = mem_mask_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.err       = err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. It runs directed scenarios and then a randomized phase.
// All checks are made against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int MAX_D = 4;
    localparam int TMO   = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_D_STREAK(MAX_D), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: owner 0 = none, 1 = fetch, 2 = data; busy counts cycles spent waiting.
    int          m_owner, m_busy, m_streak;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    logic        m_we, m_if_done, m_d_done, m_err;
    logic [3:0]  m_mask;

    // Inputs as sampled at the upcoming rising edge.
    logic        p_if_req, p_d_req, p_d_we, p_mem_ack, p_rst_n;
    logic [31:0] p_if_addr, p_d_addr, p_d_wdata, p_mem_rdata;
    logic [3:0]  p_d_mask;

    // Stimulus control.
    bit          rand_mode, d_rearm;
    int          fixed_lat, cur_lat, wait_cnt, d_seq, grants, busy;
    logic        mem_req_prev, prev_req, seen;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_busy = 0; m_streak = 0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_mask = '0;
        m_if_rdata = '0; m_d_rdata = '0;
        m_if_done = 1'b0; m_d_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step();
        logic nid, ndd, nerr;
        nid = 1'b0; ndd = 1'b0; nerr = 1'b0;
        if (!p_rst_n) begin
            model_reset();
            return;
        end
        if (m_owner == 0) begin
            if (!m_if_done && !m_d_done) begin
                if (p_d_req && (!p_if_req || m_streak < MAX_D)) begin
                    m_owner = 2; m_busy = 0;
                    m_addr = p_d_addr; m_we = p_d_we; m_wdata = p_d_wdata; m_mask = p_d_mask;
                    m_streak = p_if_req ? ((m_streak < MAX_D) ? m_streak + 1 : MAX_D) : 0;
                end else if (p_if_req) begin
                    m_owner = 1; m_busy = 0;
                    m_addr = p_if_addr; m_we = 1'b0; m_mask = 4'b0000;
                    m_streak = 0;
                end
            end
        end else begin
            m_busy++;
            if (p_mem_ack) begin
                if (m_owner == 1) begin
                    nid = 1'b1; m_if_rdata = p_mem_rdata;
                end else begin
                    ndd = 1'b1;
                    if (!m_we) m_d_rdata = p_mem_rdata;
                end
                m_owner = 0;
            end else if (m_busy == TMO) begin
                nerr = 1'b1;
                if (m_owner == 1) begin
                    nid = 1'b1; m_if_rdata = '0;
                end else begin
                    ndd = 1'b1; m_d_rdata = '0;
                end
                m_owner = 0;
            end
        end
        m_if_done = nid; m_d_done = ndd; m_err = nerr;
    endtask

    task automatic compare_all();
        logic e_req, e_stall;
        e_req   = (m_owner != 0);
        e_stall = (p_if_req & ~m_if_done) | (p_d_req & ~m_d_done);
        chk("mem_req", 32'(bus.mem_req), 32'(e_req));
        chk("if_done", 32'(bus.if_done), 32'(m_if_done));
        chk("d_done", 32'(bus.d_done), 32'(m_d_done));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("if_rdata", bus.if_rdata, m_if_rdata);
        chk("d_rdata", bus.d_rdata, m_d_rdata);
        chk("stall", 32'(bus.stall), 32'(e_stall));
        if (e_req) begin
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_we", 32'(bus.mem_we), 32'(m_we));
            chk("mem_mask", 32'(bus.mem_mask), 32'(m_mask));
            if (m_owner == 2) chk("mem_wdata", bus.mem_wdata, m_wdata);
        end
    endtask

    task automatic drive_mem();
        if (bus.mem_req) begin
            if (!mem_req_prev) begin
                wait_cnt = 0;
                cur_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 9));
            end else begin
                wait_cnt++;
            end
            bus.mem_ack   = (wait_cnt == cur_lat);
            bus.mem_rdata = rd_of(bus.mem_addr);
        end else begin
            bus.mem_ack   = rand_mode && ($urandom_range(0, 9) == 0);
            bus.mem_rdata = $urandom;
        end
        mem_req_prev = bus.mem_req;
    endtask

    task automatic new_d();
        if (rand_mode) begin
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = $urandom & 32'hFFFF_FFFC;
            bus.d_wdata = $urandom;
            bus.d_mask  = 4'($urandom_range(0, 15));
        end else begin
            bus.d_we    = 1'b0;
            bus.d_addr  = 32'h1000 + 32'(d_seq * 4);
            bus.d_wdata = 32'h0;
            bus.d_mask  = 4'hF;
        end
    endtask

    task automatic drive_reqs();
        if (bus.d_req && bus.d_done) begin
            if (d_rearm || (rand_mode && $urandom_range(0, 3) != 0)) begin
                d_seq++;
                new_d();
            end else begin
                bus.d_req = 1'b0;
            end
        end else if (rand_mode) begin
            if (!bus.d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.d_req = 1'b1;
                    new_d();
                end
            end else if ($urandom_range(0, 4) == 0) begin
                new_d();
            end
        end
        if (bus.if_req && bus.if_done) begin
            if (rand_mode && $urandom_range(0, 1) == 0) bus.if_addr = $urandom & 32'hFFFF_FFFC;
            else bus.if_req = 1'b0;
        end else if (rand_mode) begin
            if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end else if (bus.if_req && $urandom_range(0, 4) == 0) begin
                bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end
        end
    endtask

    // One clock: capture the inputs seen at the rising edge, then check and re-drive at the falling edge.
    task automatic step();
        p_if_req = bus.if_req; p_if_addr = bus.if_addr;
        p_d_req = bus.d_req; p_d_we = bus.d_we; p_d_addr = bus.d_addr;
        p_d_wdata = bus.d_wdata; p_d_mask = bus.d_mask;
        p_mem_ack = bus.mem_ack; p_mem_rdata = bus.mem_rdata; p_rst_n = rst_n;
        @(negedge clk);
        model_step();
        compare_all();
        drive_mem();
        drive_reqs();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mask = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        rand_mode = 1'b0; d_rearm = 1'b0; fixed_lat = 0; d_seq = 0;
        mem_req_prev = 1'b0;
        model_reset();

        // Reset state
        step(); step();
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_mask", 32'(bus.mem_mask), 32'd0);
        chk("rst_if_done", 32'(bus.if_done), 32'd0);
        chk("rst_d_done", 32'(bus.d_done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        rst_n = 1'b1;
        step();

        // Single fetch against a zero-wait memory
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        #1 chk("t1_stall_c0", 32'(bus.stall), 32'd1);
        step();
        chk("t1_mem_req", 32'(bus.mem_req), 32'd1);
        chk("t1_mem_addr", bus.mem_addr, 32'h100);
        chk("t1_mem_we", 32'(bus.mem_we), 32'd0);
        chk("t1_stall_c1", 32'(bus.stall), 32'd1);
        bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("t1_if_done", 32'(bus.if_done), 32'd1);
        chk("t1_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        chk("t1_stall_c2", 32'(bus.stall), 32'd0);
        step();
        chk("t1_done_pulse", 32'(bus.if_done), 32'd0);

        // Simultaneous requests: data first, fetch three cycles later
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000; bus.d_mask = 4'b0011;
        step();
        chk("t2_d_addr", bus.mem_addr, 32'h2000);
        chk("t2_d_mask", 32'(bus.mem_mask), 32'h3);
        step();
        chk("t2_d_done", 32'(bus.d_done), 32'd1);
        chk("t2_d_rdata", bus.d_rdata, rd_of(32'h2000));
        step(); step();
        chk("t2_i_addr", bus.mem_addr, 32'h200);
        chk("t2_i_mask", 32'(bus.mem_mask), 32'h0);
        step();
        chk("t2_if_done", 32'(bus.if_done), 32'd1);
        chk("t2_if_rdata", bus.if_rdata, rd_of(32'h200));
        step();

        // Data streak limit: four data grants, then the fetch, then data again
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        d_seq = 0; d_rearm = 1'b1;
        bus.d_req = 1'b1; new_d();
        exp_q = {32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h300, 32'h1010};
        grants = 0;
        for (int n = 0; n < 80 && grants < 6; n++) begin
            prev_req = bus.mem_req;
            step();
            if (bus.mem_req && !prev_req) begin
                chk("t3_grant_addr", bus.mem_addr, exp_q.pop_front());
                grants++;
            end
        end
        chk("t3_grants", 32'(grants), 32'd6);
        d_rearm = 1'b0;
        for (int n = 0; n < 20 && bus.d_req; n++) step();
        chk("t3_drain", 32'(bus.d_req), 32'd0);
        step();

        // Store leaves d_rdata at the previous load value
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2004; bus.d_mask = 4'hF;
        step(); step();
        chk("t4_load_rdata", bus.d_rdata, rd_of(32'h2004));
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40;
        bus.d_wdata = 32'h1234_5678; bus.d_mask = 4'b1111;
        step();
        chk("t4_mem_we", 32'(bus.mem_we), 32'd1);
        chk("t4_mem_addr", bus.mem_addr, 32'h40);
        chk("t4_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        chk("t4_mem_mask", 32'(bus.mem_mask), 32'hF);
        step();
        chk("t4_d_done", 32'(bus.d_done), 32'd1);
        chk("t4_d_rdata_held", bus.d_rdata, rd_of(32'h2004));
        bus.d_we = 1'b0;
        step();

        // Hung memory: abort after TIMEOUT busy cycles
        fixed_lat = 99;
        bus.d_req = 1'b1; bus.d_addr = 32'h80;
        busy = 0; seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            step();
            if (bus.mem_req) busy++;
            if (bus.d_done) seen = 1'b1;
        end
        chk("t5_done_seen", 32'(seen), 32'd1);
        chk("t5_busy_cycles", 32'(busy), 32'(TMO));
        chk("t5_err", 32'(bus.err), 32'd1);
        chk("t5_d_rdata", bus.d_rdata, 32'd0);
        step();
        chk("t5_err_pulse", 32'(bus.err), 32'd0);
        fixed_lat = 0;
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        step(); step();
        chk("t5_next_done", 32'(bus.if_done), 32'd1);
        chk("t5_next_rdata", bus.if_rdata, rd_of(32'h400));
        chk("t5_next_err", 32'(bus.err), 32'd0);
        step();

        // Reset in the middle of a data access
        fixed_lat = 99;
        bus.d_req = 1'b1; bus.d_addr = 32'h90;
        step();
        chk("t6_busy", 32'(bus.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_req", 32'(bus.mem_req), 32'd0);
        chk("t6_async_done", 32'(bus.d_done), 32'd0);
        model_reset();
        fixed_lat = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("t6_regrant", 32'(bus.mem_req), 32'd1);
        chk("t6_regrant_addr", bus.mem_addr, 32'h90);
        step();
        chk("t6_done", 32'(bus.d_done), 32'd1);
        chk("t6_rdata", bus.d_rdata, rd_of(32'h90));
        step();

        // Randomized traffic with random memory latency (including timeouts)
        rand_mode = 1'b1; fixed_lat = -1;
        for (int n = 0; n < 2000; n++) step();
        rand_mode = 1'b0;
        for (int n = 0; n < 60 && (bus.if_req || bus.d_req); n++) step();
        chk("rand_drain", 32'(bus.if_req | bus.d_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the CPU instruction-fetch requester and the data-access requester (load/store with sign mask).
- Arbitrates between the two, sequences each memory transaction with a req/ack handshake and returns read data with a done pulse.
- Drives a pipeline stall, and guards against data-side starvation of fetch and against a hung memory.
- Sits between the cpu top level and the memory wrapper.

Parameters:
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch is forced (1..15).
- TIMEOUT, 255, cycles in BUSY without mem_ack before abort (1..255, 8-bit counter).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset; active-low, asynchronous assert.
- if_req  in  1  fetch request, held high until if_done.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetch data, registered, valid with if_done.
- if_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request, held high until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_mask  in  4  sign/byte mask passed to memory.
- d_rdata  out  32  load data, registered, valid with d_done.
- d_done  out  1  one-cycle completion pulse for data.
- err  out  1  one-cycle pulse with done when the transaction timed out.
- stall  out  1  combinational: (if_req & ~if_done) | (d_req & ~d_done).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  32  registered.
- mem_wdata  out  32  registered.
- mem_mask  out  4  registered.
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including mem_req, done, err, rdata and mem_* fields; streak and timeout counters 0. mem_req drops immediately mid-transaction; the in-flight access is abandoned with no done pulse.
- States are IDLE, BUSY_I and BUSY_D.
- IDLE grant decision (requests whose done is high this cycle are ignored, so there is no re-grant in the done cycle):
  - Data wins if d_req and (~if_req or streak < MAX_D_STREAK).
  - Otherwise fetch wins if if_req.
  - Otherwise stay in IDLE.
- On grant edge: latch address, we, wdata and mask into mem_*; set mem_req=1; enter BUSY_x. A fetch grant forces mem_we=0 and mem_mask=4'b0000.
- Streak counter:
  - D grant with if_req high: streak+1, saturating at MAX_D_STREAK.
  - D grant with if_req low: streak=0.
  - I grant: streak=0.
- BUSY_x with mem_ack=1:
  - Next edge: mem_req=0, state IDLE, x_done=1 for exactly one cycle.
  - Reads: rdata register loads mem_rdata.
  - Stores: d_rdata holds its previous value.
- BUSY_x with mem_ack=0: timeout counter increments. When it reaches TIMEOUT, the next edge sets mem_req=0, state IDLE, x_done=1, err=1 and x_rdata=0. The counter clears on every grant.
- mem_ack in IDLE is ignored.
- Latency: zero-wait memory gives req seen (cycle 0) -> mem_req (cycle 1, ack) -> done (cycle 2). Minimum 3 cycles req-to-done; back-to-back throughput is one transaction per 3 cycles.
- Address and data inputs are sampled only at the grant edge; later changes while BUSY have no effect.
- Simultaneous first requests from IDLE with streak 0: data wins.
- Done pulses never overlap; at most one of if_done and d_done is high in any cycle.

Test Plan:
- Reset then if_req=1, if_addr=0x100, mem_ack one cycle after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=0x100 and mem_we=0; if_done pulses in cycle 2 with if_rdata=0xDEADBEEF; stall high in cycles 0-1 and low in cycle 2.
- if_req and d_req (load, 0x2000) raised in the same cycle -> data granted first; d_done precedes if_done by 3 cycles; then fetch is serviced.
- if_req held high and d_req re-raised immediately after every d_done, MAX_D_STREAK=4 -> exactly 4 data transactions, then one fetch, then data resumes; streak resets.
- Store d_we=1, d_addr=0x40, d_wdata=0x12345678, d_mask=4'b1111 -> mem_we=1 with those values latched; d_done pulses; d_rdata unchanged from the prior load value.
- mem_ack never asserted, TIMEOUT=8 -> mem_req drops after 8 busy cycles; done and err pulse together with rdata=0; next request is granted normally.
- rst_n pulled low while BUSY_D with mem_req=1 -> mem_req=0 immediately, no d_done; after release, a held d_req is re-granted from IDLE.
